// File: rtl/mac_seq_ctrl_if.sv
// rtl/mac_seq_ctrl_if.sv - operand, counter and result signal bundle for mac_seq_ctrl
//
// Groups every non-clock/reset port of mac_seq_ctrl.
//   i_start      : begin a new vector (honoured in IDLE only)
//   i_a, i_b     : signed operand pair, qualified by i_valid / o_in_ready
//   i_cnt_f      : element counter terminal flag (count == 8)
//   o_cnt_en     : element counter increment enable
//   o_rst_mac    : element counter clear
//   o_result     : signed accumulated sum, qualified by o_out_valid / i_out_ready
//   o_busy       : block is in ACC or DONE
// Modport slave is the sequencer's view; master is the surrounding logic's view.

interface mac_seq_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
);

  logic              i_start;
  logic [DATA_W-1:0] i_a;
  logic [DATA_W-1:0] i_b;
  logic              i_valid;
  logic              o_in_ready;
  logic              i_cnt_f;
  logic              o_cnt_en;
  logic              o_rst_mac;
  logic [ACC_W-1:0]  o_result;
  logic              o_out_valid;
  logic              i_out_ready;
  logic              o_busy;

  modport slave (
    input  i_start,
    input  i_a,
    input  i_b,
    input  i_valid,
    output o_in_ready,
    input  i_cnt_f,
    output o_cnt_en,
    output o_rst_mac,
    output o_result,
    output o_out_valid,
    input  i_out_ready,
    output o_busy
  );

  modport master (
    output i_start,
    output i_a,
    output i_b,
    output i_valid,
    input  o_in_ready,
    output i_cnt_f,
    input  o_cnt_en,
    input  o_rst_mac,
    input  o_result,
    input  o_out_valid,
    output i_out_ready,
    input  o_busy
  );

endinterface

// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - multiply-accumulate sequencer driving an 8-element counter
//
// Accepts signed operand pairs, accumulates their products, and hands the
// sum downstream once the external element counter reports the vector is
// complete.
//   i_clk : rising-edge clock
//   i_rst : asynchronous active-high reset
//   bus   : mac_seq_ctrl_if.slave (operand stream, counter control, result stream)

module mac_seq_ctrl #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic            i_clk,
  input  logic            i_rst,
  mac_seq_ctrl_if.slave   bus
);

  localparam int PROD_W = 2 * DATA_W;

  // Eight full-scale products need three guard bits above the product width.
  if (ACC_W < PROD_W + 3) begin : g_acc_w_check
    $error("mac_seq_ctrl: ACC_W too small for 8 full-scale products");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   result_q, result_d;

  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic signed [PROD_W-1:0] prod;
  logic [ACC_W-1:0]         prod_ext;

  logic in_ready;
  logic accept;

  assign a_s      = $signed(bus.i_a);
  assign b_s      = $signed(bus.i_b);
  assign prod     = a_s * b_s;
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    acc_d           = acc_q;
    result_d        = result_q;
    in_ready        = 1'b0;
    accept          = 1'b0;
    bus.o_cnt_en    = 1'b0;
    bus.o_rst_mac   = 1'b0;
    bus.o_out_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Hold the counter at zero so a stale count never leaks into ACC.
        bus.o_rst_mac = 1'b1;
        if (bus.i_start) begin
          acc_d   = '0;
          state_d = ST_ACC;
        end
      end

      ST_ACC: begin
        // Once the counter reaches its terminal value no more pairs fit.
        in_ready     = ~bus.i_cnt_f;
        accept       = bus.i_valid & in_ready;
        bus.o_cnt_en = accept;
        if (accept) begin
          acc_d = acc_q + prod_ext;
        end
        // accept is impossible here when i_cnt_f is high, so acc_q is final.
        if (bus.i_cnt_f) begin
          result_d = acc_q;
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        bus.o_out_valid = 1'b1;
        // i_start is deliberately not looked at: a fresh request is needed in IDLE.
        if (bus.i_out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.o_in_ready = in_ready;
  assign bus.o_result   = result_q;
  assign bus.o_busy     = (state_q == ST_ACC) | (state_q == ST_DONE);

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb/tb_mac_seq_ctrl.sv - self-checking bench for mac_seq_ctrl with an element counter model

module tb_mac_seq_ctrl;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mac_seq_ctrl_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) intf ();

  mac_seq_ctrl #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (intf.slave)
  );

  // Element counter model: clears on o_rst_mac, counts enables up to 8.
  logic [3:0] cnt;
  logic       force_f = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst)                                cnt <= 4'd0;
    else if (intf.o_rst_mac)                cnt <= 4'd0;
    else if (intf.o_cnt_en && cnt != 4'd8)  cnt <= cnt + 4'd1;
  end
  assign intf.i_cnt_f = (cnt == 4'd8) | force_f;

  int en_pulses = 0;
  always @(posedge clk) if (intf.o_cnt_en) en_pulses <= en_pulses + 1;

  int tests  = 0;
  int failed = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  int op_a [8];
  int op_b [8];
  int gap  [8];

  // Reference: exact integer sum of products, reduced modulo 2^ACC_W, read as signed.
  function automatic int ref_sum();
    longint s = 0;
    logic [ACC_W-1:0] w;
    for (int i = 0; i < 8; i++) s += longint'(op_a[i] * op_b[i]);
    w = s[ACC_W-1:0];
    return int'($signed(w));
  endfunction

  function automatic int res_s();
    return int'($signed(intf.o_result));
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    intf.i_start = 1'b1;
    step();
    intf.i_start = 1'b0;
  endtask

  // Runs one vector from op_a/op_b/gap; caller is at a negedge in IDLE.
  task automatic run_vec(input string name, input int exp, input int hold,
                         input bit spur, input bit ninth);
    int en0;
    int guard;
    en0 = en_pulses;
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < gap[i]; g++) begin
        intf.i_valid = 1'b0;
        #1 chk({name, " bubble no cnt_en"}, int'(intf.o_cnt_en), 0);
        step();
      end
      intf.i_valid = 1'b1;
      intf.i_a = op_a[i][DATA_W-1:0];
      intf.i_b = op_b[i][DATA_W-1:0];
      #1;
      guard = 0;
      while (!intf.o_in_ready && guard < 20) begin
        step();
        #1 guard++;
      end
      if (guard >= 20) chk({name, " accept timeout"}, 0, 1);
      if (i == 0 || i == 7) chk({name, " cnt_en on accept"}, int'(intf.o_cnt_en), 1);
      step();
      intf.i_valid = 1'b0;
    end
    // Cycle T+1: counter reads 8, no more input taken, no result yet.
    if (ninth) begin
      intf.i_valid = 1'b1;
      intf.i_a = 8'd1;
      intf.i_b = 8'd1;
    end
    #1;
    chk({name, " T+1 in_ready"}, int'(intf.o_in_ready), 0);
    chk({name, " T+1 cnt_en"}, int'(intf.o_cnt_en), 0);
    chk({name, " T+1 out_valid"}, int'(intf.o_out_valid), 0);
    step();
    intf.i_valid = 1'b0;
    #1;
    chk({name, " T+2 out_valid"}, int'(intf.o_out_valid), 1);
    chk({name, " result"}, res_s(), exp);
    chk({name, " cnt_en pulses"}, en_pulses - en0, 8);
    for (int h = 0; h < hold; h++) begin
      intf.i_start = spur;
      step();
      intf.i_start = 1'b0;
      #1;
      chk({name, " hold out_valid"}, int'(intf.o_out_valid), 1);
      chk({name, " hold result"}, res_s(), exp);
    end
    // Handshake; an i_start in this cycle must not launch a new vector.
    intf.i_out_ready = 1'b1;
    intf.i_start = spur;
    step();
    intf.i_out_ready = 1'b0;
    intf.i_start = 1'b0;
    #1;
    chk({name, " idle out_valid"}, int'(intf.o_out_valid), 0);
    chk({name, " idle rst_mac"}, int'(intf.o_rst_mac), 1);
    step();
    #1 chk({name, " stays idle"}, int'(intf.o_busy), 0);
  endtask

  typedef struct {
    string name;
    int    a0;
    int    a_step;
    int    b;
    int    gap_n;
    int    exp;
    int    hold;
    bit    spur;
    bit    ninth;
  } vec_t;

  vec_t vecs [5];

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < 8; i++) begin
      op_a[i] = v.a0 + i * v.a_step;
      op_b[i] = v.b;
      gap[i]  = (i == 0) ? 0 : v.gap_n;
    end
  endtask

  initial begin
    vecs[0] = '{"basic",    1,    1,  2,   0, 72,      0, 1'b0, 1'b0};
    vecs[1] = '{"ext_neg",  -128, 0,  -128, 0, 131072,  0, 1'b0, 1'b0};
    vecs[2] = '{"ext_mix",  -128, 0,  127, 0, -130048, 0, 1'b0, 1'b0};
    vecs[3] = '{"bubbles",  3,    0,  -5,  2, -120,    0, 1'b0, 1'b1};
    vecs[4] = '{"backpres", 2,    1,  3,   0, 132,     5, 1'b1, 1'b0};

    intf.i_start = 1'b0;
    intf.i_valid = 1'b0;
    intf.i_a = '0;
    intf.i_b = '0;
    intf.i_out_ready = 1'b0;

    #2;
    chk("reset out_valid", int'(intf.o_out_valid), 0);
    chk("reset in_ready",  int'(intf.o_in_ready), 0);
    chk("reset cnt_en",    int'(intf.o_cnt_en), 0);
    chk("reset rst_mac",   int'(intf.o_rst_mac), 1);
    chk("reset busy",      int'(intf.o_busy), 0);
    chk("reset result",    res_s(), 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    for (int v = 0; v < 5; v++) begin
      load_vec(vecs[v]);
      run_vec(vecs[v].name, vecs[v].exp, vecs[v].hold, vecs[v].spur, vecs[v].ninth);
    end

    // Reset after three accepts discards the partial sum.
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      intf.i_valid = 1'b1;
      intf.i_a = 8'd50;
      intf.i_b = 8'd50;
      step();
    end
    intf.i_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst out_valid", int'(intf.o_out_valid), 0);
    chk("midrst in_ready",  int'(intf.o_in_ready), 0);
    chk("midrst rst_mac",   int'(intf.o_rst_mac), 1);
    chk("midrst busy",      int'(intf.o_busy), 0);
    step();
    rst = 1'b0;
    step();
    load_vec('{"ones", 1, 0, 1, 0, 8, 0, 1'b0, 1'b0});
    run_vec("after_rst", 8, 0, 1'b0, 1'b0);

    // Stale counter flag on ACC entry: nothing accepted, result zero.
    force_f = 1'b1;
    pulse_start();
    intf.i_valid = 1'b1;
    intf.i_a = 8'd7;
    intf.i_b = 8'd7;
    #1;
    chk("stale in_ready", int'(intf.o_in_ready), 0);
    chk("stale cnt_en",   int'(intf.o_cnt_en), 0);
    step();
    intf.i_valid = 1'b0;
    #1;
    chk("stale out_valid", int'(intf.o_out_valid), 1);
    chk("stale result",    res_s(), 0);
    intf.i_out_ready = 1'b1;
    step();
    intf.i_out_ready = 1'b0;
    force_f = 1'b0;
    #1 chk("stale back idle", int'(intf.o_busy), 0);
    step();

    // Randomized vectors against the arithmetic reference.
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 8; i++) begin
        op_a[i] = int'($urandom_range(0, 255)) - 128;
        op_b[i] = int'($urandom_range(0, 255)) - 128;
        gap[i]  = int'($urandom_range(0, 2));
      end
      run_vec($sformatf("rand%0d", r), ref_sum(), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Multiply-accumulate sequencer that sits directly downstream of the team's element counter.
- Accepts a stream of signed operand pairs over a valid/ready handshake and accumulates their products.
- Drives the counter's enable and MAC-reset inputs, and consumes its terminal flag to know when the vector (8 elements) is complete.
- Presents the accumulated result over a valid/ready output handshake to the next stage.

Parameters:
- DATA_W, 8: width of each signed operand.
- ACC_W, 20: width of the signed accumulator and result. Must be >= 2*DATA_W+3 to hold 8 full-scale products without wrap.

Ports:
- i_clk  input  1  rising-edge clock.
- i_rst  input  1  asynchronous, active-high reset.
- i_start  input  1  single-cycle request to begin a new vector. Honoured only in IDLE.
- i_a  input  DATA_W  signed operand A.
- i_b  input  DATA_W  signed operand B.
- i_valid  input  1  operand pair valid.
- o_in_ready  output  1  block can accept an operand pair.
- i_cnt_f  input  1  terminal flag from the element counter (high when the count equals 8).
- o_cnt_en  output  1  counter increment enable.
- o_rst_mac  output  1  counter clear, active-high.
- o_result  output  ACC_W  signed accumulated sum.
- o_out_valid  output  1  o_result is valid.
- i_out_ready  input  1  downstream accepts the result.
- o_busy  output  1  high in ACC or DONE.

Behaviour:
- Reset (async, i_rst=1):
  - State goes to IDLE; acc=0; o_result=0.
  - o_out_valid=0, o_in_ready=0, o_cnt_en=0, o_rst_mac=1, o_busy=0.
- States: IDLE, ACC, DONE. State is registered; outputs are decoded from state plus the listed inputs.
- IDLE:
  - o_rst_mac=1 continuously, holding the counter at 0.
  - On i_start=1: acc<=0 and go to ACC on the next edge.
- ACC:
  - o_rst_mac=0.
  - o_in_ready = ~i_cnt_f.
  - Accept condition: i_valid & o_in_ready. On accept, acc <= acc + sext(i_a*i_b), and o_cnt_en=1 in the same cycle (o_cnt_en = i_valid & o_in_ready, combinational). No accept means no enable.
  - If i_cnt_f=1, go to DONE on the next edge and latch o_result <= acc at that edge.
  - If i_cnt_f is already 1 on the first ACC cycle, go to DONE with acc=0. No operand is accepted.
- DONE:
  - o_out_valid=1; o_in_ready=0; o_cnt_en=0; o_rst_mac=0.
  - o_result is held stable until the handshake completes.
  - On i_out_ready=1, go to IDLE on the next edge; o_out_valid drops in that next cycle.
- Latency: 8th accept at cycle T; counter reads 8 at T+1 (i_cnt_f=1, o_in_ready=0); o_out_valid=1 from T+2.
- Arithmetic:
  - Signed product is 2*DATA_W bits, sign-extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W. No saturation.
- i_start outside IDLE is ignored with no side effect.
- i_start in the same cycle as the DONE handshake is ignored; the block enters IDLE and requires a fresh i_start.
- Reset mid-operation: all partial accumulation is discarded. o_rst_mac=1 (IDLE) re-clears the counter. No result is emitted.
- o_busy = (state==ACC) | (state==DONE).

Test Plan:
- Bench connects an 8-count counter model to o_cnt_en/o_rst_mac/i_cnt_f.
- Basic run: i_start, then a=1..8, b=2 with i_valid held high, i_out_ready=1 -> exactly 8 o_cnt_en pulses; o_out_valid high 2 cycles after the 8th accept; o_result=72; back to IDLE with o_rst_mac=1.
- Signed extremes: a=-128, b=-128 ×8 -> o_result=131072. a=-128, b=127 ×8 -> o_result=-130048 (20-bit two's complement).
- Bubbles: i_valid toggled 1,0,0,1,... over 8 pairs of a=3, b=-5 -> o_cnt_en only on accept cycles; o_result=-120; o_in_ready=0 once i_cnt_f=1, and a 9th offered pair is not accepted.
- Backpressure and spurious start: i_out_ready low for 5 cycles in DONE, i_start pulsed during that window -> o_out_valid and o_result stable; no state change; the run completes normally when i_out_ready rises.
- Reset mid-ACC: i_rst asserted after 3 accepts -> immediately o_out_valid=0, o_in_ready=0, o_rst_mac=1. A following run of a=1, b=1 ×8 -> o_result=8.
- Stale counter: force i_cnt_f=1 on entry to ACC -> no accepts; DONE with o_result=0.
